// File: rtl/ocp_slave_fsm_pkg.sv
// Shared OCP encodings, default widths and slave FSM state type for ocp_slave_fsm.
package ocp_slave_fsm_pkg;

  localparam int DEF_MADDR_WIDTH = 64;
  localparam int DEF_MDATA_WIDTH = 8;
  localparam int DEF_SDATA_WIDTH = 8;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;
  localparam logic [2:0] CMD_RDEX = 3'b011;
  localparam logic [2:0] CMD_RDL  = 3'b100;
  localparam logic [2:0] CMD_WRNP = 3'b101;

  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_RWAIT = 2'd2,
    S_RESP  = 2'd3
  } slave_state_e;

  function automatic logic is_write(input logic [2:0] cmd);
    return (cmd == CMD_WR) || (cmd == CMD_WRNP);
  endfunction

  function automatic logic is_read(input logic [2:0] cmd);
    return (cmd == CMD_RD) || (cmd == CMD_RDEX) || (cmd == CMD_RDL);
  endfunction

endpackage

// File: rtl/ocp_slave_fsm_mem.sv
// Local word store for ocp_slave_fsm: synchronous write, asynchronous read by index.
module ocp_slave_fsm_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     Clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents survive reset on purpose; only the write port updates them.
  always_ff @(posedge Clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ocp_slave_fsm.sv
// OCP slave endpoint with word store and fixed read latency.
// Optional macro OCP_SLAVE_ADDR_CHECK_EN: flag MAddr >= MEM_DEPTH as out of range (ERR / dropped write).
module ocp_slave_fsm
  import ocp_slave_fsm_pkg::*;
#(
  parameter int MADDR_WIDTH = DEF_MADDR_WIDTH,
  parameter int MDATA_WIDTH = DEF_MDATA_WIDTH,
  parameter int SDATA_WIDTH = DEF_SDATA_WIDTH,
  parameter int MEM_DEPTH   = 16,
  parameter int RD_WAIT     = 2
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   EnableClk,
  input  logic [2:0]             MCmd,
  input  logic [MADDR_WIDTH-1:0] MAddr,
  input  logic [MDATA_WIDTH-1:0] MData,
  input  logic                   MDataValid,
  output logic                   SCmdAccept,
  output logic                   SDataAccept,
  output logic [1:0]             SResp,
  output logic [SDATA_WIDTH-1:0] SData
);

  localparam int         IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);

  slave_state_e     r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_addr_ok;
  logic             r_wrnp;
  logic [3:0]       r_cnt;
  logic [1:0]       r_resp;
  logic             r_resp_rd;

  logic                   w_cmd_fire;
  logic                   w_data_fire;
  logic                   w_addr_ok;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_we;
  logic [IDX_W-1:0]       w_widx;
  logic [SDATA_WIDTH-1:0] w_rdata;

  assign w_idx = MAddr[IDX_W-1:0];

`ifdef OCP_SLAVE_ADDR_CHECK_EN
  assign w_addr_ok = ~|MAddr[MADDR_WIDTH-1:IDX_W];
`else
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^MAddr[MADDR_WIDTH-1:IDX_W];
  assign w_addr_ok        = 1'b1;
`endif

  // Handshake strobes: commands only in S_IDLE, data in S_IDLE (same-cycle) or S_WDATA.
  always_comb begin
    SCmdAccept  = 1'b0;
    SDataAccept = 1'b0;
    if (reset) begin
      SCmdAccept  = 1'b0;
      SDataAccept = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          SCmdAccept  = (MCmd != CMD_IDLE);
          SDataAccept = is_write(MCmd) & MDataValid;
        end
        S_WDATA: begin
          SCmdAccept  = 1'b0;
          SDataAccept = 1'b1;
        end
        default: begin
          SCmdAccept  = 1'b0;
          SDataAccept = 1'b0;
        end
      endcase
    end
  end

  assign w_cmd_fire  = EnableClk & SCmdAccept;
  assign w_data_fire = EnableClk & SDataAccept & MDataValid;
  // Same-cycle data uses the live address; late data uses the captured one.
  assign w_we        = w_data_fire & ((r_state == S_IDLE) ? w_addr_ok : r_addr_ok);
  assign w_widx      = (r_state == S_IDLE) ? w_idx : r_idx;

  ocp_slave_fsm_mem #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (SDATA_WIDTH)
  ) u_mem (
    .Clk     (Clk),
    .i_we    (w_we),
    .i_waddr (w_widx),
    .i_wdata (MData),
    .i_raddr (r_idx),
    .o_rdata (w_rdata)
  );

  // Main FSM; SResp/SData are loaded on the enabled edge leaving S_RESP.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_addr_ok <= 1'b1;
      r_wrnp    <= 1'b0;
      r_cnt     <= 4'd0;
      r_resp    <= RESP_NULL;
      r_resp_rd <= 1'b0;
      SResp     <= RESP_NULL;
      SData     <= '0;
    end else if (EnableClk) begin
      SResp <= RESP_NULL;
      SData <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_idx     <= w_idx;
            r_addr_ok <= w_addr_ok;
            r_wrnp    <= (MCmd == CMD_WRNP);
            if (is_write(MCmd)) begin
              r_resp    <= w_addr_ok ? RESP_DVA : RESP_ERR;
              r_resp_rd <= 1'b0;
              if (!MDataValid) begin
                r_state <= S_WDATA;
              end else if (MCmd == CMD_WRNP) begin
                r_state <= S_RESP;
              end else begin
                r_state <= S_IDLE;
              end
            end else if (is_read(MCmd)) begin
              r_resp    <= w_addr_ok ? RESP_DVA : RESP_ERR;
              r_resp_rd <= 1'b1;
              r_cnt     <= RD_WAIT_C;
              r_state   <= (RD_WAIT == 0) ? S_RESP : S_RWAIT;
            end else begin
              r_resp    <= RESP_ERR;
              r_resp_rd <= 1'b0;
              r_state   <= S_RESP;
            end
          end
        end
        S_WDATA: begin
          if (w_data_fire) begin
            r_state <= r_wrnp ? S_RESP : S_IDLE;
          end
        end
        S_RWAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          SResp   <= r_resp;
          SData   <= (r_resp_rd && (r_resp == RESP_DVA)) ? w_rdata : '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ocp_slave_fsm.sv
// Scoreboard bench for ocp_slave_fsm: driver queues expected responses, monitor checks them.
module tb_ocp_slave_fsm;
  import ocp_slave_fsm_pkg::*;

  localparam logic [2:0] CMD_BCST = 3'b111;
  localparam int         RDW      = 2;

  typedef struct {
    string      name;
    logic [1:0] resp;
    logic [7:0] data;
    int         at;
  } exp_t;

  logic        Clk = 1'b0;
  logic        reset;
  logic        EnableClk;
  logic [2:0]  MCmd;
  logic [63:0] MAddr;
  logic [7:0]  MData;
  logic        MDataValid;
  logic        SCmdAccept;
  logic        SDataAccept;
  logic [1:0]  SResp;
  logic [7:0]  SData;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  ocp_slave_fsm dut (
    .Clk         (Clk),
    .reset       (reset),
    .EnableClk   (EnableClk),
    .MCmd        (MCmd),
    .MAddr       (MAddr),
    .MData       (MData),
    .MDataValid  (MDataValid),
    .SCmdAccept  (SCmdAccept),
    .SDataAccept (SDataAccept),
    .SResp       (SResp),
    .SData       (SData)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input string name, input logic [1:0] resp, input logic [7:0] data, input int at);
    exp_t e;
    e.name = name; e.resp = resp; e.data = data; e.at = at;
    sb.push_back(e);
  endtask

  // Drive one command for one cycle; returns the index of the accepting edge.
  task automatic issue(input string name, input logic [2:0] cmd, input logic [63:0] addr,
                       input logic [7:0] data, input logic dv, input logic exp_sda, output int acc);
    MCmd = cmd; MAddr = addr; MData = data; MDataValid = dv;
    #1;
    check({name, " SCmdAccept"}, {31'd0, SCmdAccept}, 32'd1);
    check({name, " SDataAccept"}, {31'd0, SDataAccept}, {31'd0, exp_sda});
    acc = cyc + 1;
    step();
    MCmd = CMD_IDLE; MDataValid = 1'b0;
  endtask

  // Monitor: every non-NULL response must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge Clk);
      if (SResp !== RESP_NULL) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: got SResp=%0h SData=%0h at cycle %0d, none expected", SResp, SData, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, " SResp"}, {30'd0, SResp}, {30'd0, e.resp});
          check({e.name, " SData"}, {24'd0, SData}, {24'd0, e.data});
          check({e.name, " cycle"}, cyc, e.at);
        end
      end
    end
  end

  initial begin
    int a;
    reset = 1'b1; EnableClk = 1'b1;
    MCmd = CMD_IDLE; MAddr = 64'd0; MData = 8'd0; MDataValid = 1'b0;
    step(); step();
    MCmd = CMD_RD;
    #1;
    check("reset SCmdAccept", {31'd0, SCmdAccept}, 32'd0);
    check("reset SResp", {30'd0, SResp}, 32'd0);
    check("reset SData", {24'd0, SData}, 32'd0);
    MCmd = CMD_IDLE;
    reset = 1'b0;
    step();

    issue("wr0", CMD_WR, 64'd0, 8'h5A, 1'b1, 1'b1, a);
    issue("wr2", CMD_WR, 64'd2, 8'h22, 1'b1, 1'b1, a);

    // Reset mid-read: the read is abandoned and never answered.
    issue("rd_abort", CMD_RD, 64'd0, 8'h00, 1'b0, 1'b0, a);
    step();
    reset = 1'b1; MCmd = CMD_RD; MAddr = 64'd3;
    #1;
    check("midreset SCmdAccept", {31'd0, SCmdAccept}, 32'd0);
    step(); step();
    reset = 1'b0; MCmd = CMD_IDLE;
    #1;
    check("postreset SResp", {30'd0, SResp}, 32'd0);
    check("postreset SData", {24'd0, SData}, 32'd0);
    repeat (5) step();

    issue("wr3", CMD_WR, 64'd3, 8'hA5, 1'b1, 1'b1, a);
    issue("rd3", CMD_RD, 64'd3, 8'h00, 1'b0, 1'b0, a);
    push("rd3", RESP_DVA, 8'hA5, a + RDW + 1);
    repeat (4) step();

    // Late write data: SDataAccept only while waiting in S_WDATA.
    issue("wr5", CMD_WR, 64'd5, 8'h00, 1'b0, 1'b0, a);
    #1;
    check("wdata SDataAccept", {31'd0, SDataAccept}, 32'd1);
    check("wdata SCmdAccept", {31'd0, SCmdAccept}, 32'd0);
    step(); step();
    MData = 8'h3C; MDataValid = 1'b1;
    #1;
    check("wdata fire SDataAccept", {31'd0, SDataAccept}, 32'd1);
    step();
    MDataValid = 1'b0;
    #1;
    check("after wdata SDataAccept", {31'd0, SDataAccept}, 32'd0);
    issue("rd5", CMD_RD, 64'd5, 8'h00, 1'b0, 1'b0, a);
    push("rd5", RESP_DVA, 8'h3C, a + RDW + 1);
    repeat (4) step();

    issue("wrnp1", CMD_WRNP, 64'd1, 8'h11, 1'b1, 1'b1, a);
    push("wrnp1", RESP_DVA, 8'h00, a + 1);
    repeat (3) step();
    issue("bcst1", CMD_BCST, 64'd1, 8'h77, 1'b1, 1'b0, a);
    push("bcst1", RESP_ERR, 8'h00, a + 1);
    repeat (3) step();
    issue("rd1", CMD_RD, 64'd1, 8'h00, 1'b0, 1'b0, a);
    push("rd1", RESP_DVA, 8'h11, a + RDW + 1);
    repeat (4) step();

    // Clock-enable stall of 4 cycles inside S_RWAIT.
    issue("rd3_stall", CMD_RD, 64'd3, 8'h00, 1'b0, 1'b0, a);
    push("rd3_stall", RESP_DVA, 8'hA5, a + RDW + 1 + 4);
    EnableClk = 1'b0;
    repeat (4) step();
    EnableClk = 1'b1;
    repeat (5) step();

    issue("rd16", CMD_RD, 64'd16, 8'h00, 1'b0, 1'b0, a);
`ifdef OCP_SLAVE_ADDR_CHECK_EN
    push("rd16", RESP_ERR, 8'h00, a + RDW + 1);
`else
    push("rd16", RESP_DVA, 8'h5A, a + RDW + 1);
`endif
    repeat (4) step();
    issue("wrnp18", CMD_WRNP, 64'd18, 8'h99, 1'b1, 1'b1, a);
`ifdef OCP_SLAVE_ADDR_CHECK_EN
    push("wrnp18", RESP_ERR, 8'h00, a + 1);
`else
    push("wrnp18", RESP_DVA, 8'h00, a + 1);
`endif
    repeat (3) step();
    issue("rd2", CMD_RD, 64'd2, 8'h00, 1'b0, 1'b0, a);
`ifdef OCP_SLAVE_ADDR_CHECK_EN
    push("rd2", RESP_DVA, 8'h22, a + RDW + 1);
`else
    push("rd2", RESP_DVA, 8'h99, a + RDW + 1);
`endif

    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++; bad++;
      $display("FAIL %s timeout: got no response, expected SResp=%0h by cycle %0d", e.name, e.resp, e.at);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
